// File: rtl/stitch_wr_arbiter_pkg.sv
// Shared types and constants for the camera-stitch frame-buffer write arbiter.
package stitch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_HDISP = 640;
  localparam int DEF_VDISP = 480;
  localparam int FRAME_PIX = DEF_HDISP * DEF_VDISP;

  localparam int CAM0 = 0;
  localparam int CAM1 = 1;

  function automatic int pix_cnt_w(input int frame_pix);
    return $clog2(frame_pix);
  endfunction

endpackage

// File: rtl/stitch_wr_arbiter_if.sv
// Command/data handshake between the write arbiter and the memory write controller.
interface stitch_wr_arbiter_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 28
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, wr_last,
    input  cmd_ready, wr_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, wr_last,
    output cmd_ready, wr_ready
  );
endinterface

// File: rtl/stitch_wr_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer hands priority to the camera
// that did not own the burst just finished.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       last_owner,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd) ptr_d = ~last_owner;
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/stitch_wr_arbiter.sv
// Shares one frame-buffer write port between two camera FIFOs, one burst at a time.
//   state | meaning
//   IDLE  | waiting for a FIFO request, pick owner
//   CMD   | burst command presented, waiting for cmd_ready
//   DATA  | streaming BURST_LEN beats from the owner's FIFO head
//   DONE  | advance/wrap owner's pixel counter, rotate priority
module stitch_wr_arbiter
  import stitch_pkg::*;
#(
  parameter int                DATA_W    = 24,
  parameter int                ADDR_W    = 28,
  parameter int                BURST_LEN = 64,
  parameter int                IMG_HDISP = DEF_HDISP,
  parameter int                IMG_VDISP = DEF_VDISP,
  parameter logic [ADDR_W-1:0] BASE0     = '0,
  parameter logic [ADDR_W-1:0] BASE1     = ADDR_W'('h010_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        src_req,
  input  logic [1:0]        src_fs,
  input  logic [DATA_W-1:0] src0_data,
  input  logic [DATA_W-1:0] src1_data,
  output logic [1:0]        src_rd_en,
  stitch_wr_arbiter_if.master mem,
  output logic [1:0]        frame_done,
  output logic [1:0]        grant
);
  localparam int              FRAME_N   = IMG_HDISP * IMG_VDISP;
  localparam int              PIX_W     = pix_cnt_w(FRAME_N);
  localparam int              BEAT_W    = 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        fs_pend_q, fs_pend_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [PIX_W-1:0]  pix_cnt_q [2];
  logic [PIX_W-1:0]  pix_cnt_d [2];
  logic [1:0]        arb_gnt;
  logic              arb_upd, cur, frame_end, fs_hit;
  logic [PIX_W:0]    pix_next;

  assign cur       = grant_q[CAM1];
  assign pix_next  = {1'b0, pix_cnt_q[cur]} + (PIX_W+1)'(BURST_LEN);
  assign frame_end = (pix_next == (PIX_W+1)'(FRAME_N));
  // a frame start seen in the DONE cycle itself counts like a pending one
  assign fs_hit    = fs_pend_q[cur] | src_fs[cur];
  assign grant     = grant_q;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (src_req),
    .upd        (arb_upd),
    .last_owner (cur),
    .gnt        (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      fs_pend_q       <= '0;
      beat_q          <= '0;
      pix_cnt_q[CAM0] <= '0;
      pix_cnt_q[CAM1] <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      fs_pend_q       <= fs_pend_d;
      beat_q          <= beat_d;
      pix_cnt_q[CAM0] <= pix_cnt_d[CAM0];
      pix_cnt_q[CAM1] <= pix_cnt_d[CAM1];
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    fs_pend_d = fs_pend_q;
    beat_d    = beat_q;
    pix_cnt_d = pix_cnt_q;
    arb_upd   = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (src_fs[s]) begin
        if (grant_q[s]) fs_pend_d[s] = 1'b1;
        else            pix_cnt_d[s] = '0;
      end
    end
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          grant_d = arb_gnt;
          beat_d  = '0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (mem.cmd_ready) state_d = DATA;
      end
      DATA: begin
        if (mem.wr_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        pix_cnt_d[cur] = (fs_hit || frame_end) ? '0 : pix_next[PIX_W-1:0];
        fs_pend_d[cur] = 1'b0;
        arb_upd        = 1'b1;
        grant_d        = '0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem.cmd_valid = 1'b0;
    mem.cmd_addr  = '0;
    mem.cmd_len   = '0;
    mem.wr_valid  = 1'b0;
    mem.wr_data   = '0;
    mem.wr_last   = 1'b0;
    src_rd_en     = '0;
    frame_done    = '0;
    case (state_q)
      CMD: begin
        mem.cmd_valid = 1'b1;
        mem.cmd_addr  = (cur ? BASE1 : BASE0) + {{(ADDR_W-PIX_W){1'b0}}, pix_cnt_q[cur]};
        mem.cmd_len   = 8'(BURST_LEN - 1);
      end
      DATA: begin
        mem.wr_valid = 1'b1;
        mem.wr_data  = cur ? src1_data : src0_data;
        mem.wr_last  = (beat_q == LAST_BEAT);
        src_rd_en    = grant_q & {2{mem.wr_ready}};
      end
      DONE: begin
        frame_done[cur] = frame_end & ~fs_hit;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_stitch_wr_arbiter.sv
// Directed bench for stitch_wr_arbiter; a 16-line frame keeps the wrap scenario short.
module tb_stitch_wr_arbiter;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 28;
  localparam int BL     = 64;
  localparam int HD     = 640;
  localparam int VD     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        src_req, src_fs, src_rd_en, frame_done, grant;
  logic [DATA_W-1:0] src0_data, src1_data;
  logic [15:0]       fptr0 = '0, fptr1 = '0;
  int                pops0 = 0, pops1 = 0, cyc = 0;
  int                checks = 0, failures = 0;
  int                exp_ptr [2] = '{0, 0};
  int                last_cmd_cyc = 0;
  int                t0;

  stitch_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

  stitch_wr_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BL),
    .IMG_HDISP(HD), .IMG_VDISP(VD),
    .BASE0(28'h000_0000), .BASE1(28'h010_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_req    (src_req),
    .src_fs     (src_fs),
    .src0_data  (src0_data),
    .src1_data  (src1_data),
    .src_rd_en  (src_rd_en),
    .mem        (mem_if),
    .frame_done (frame_done),
    .grant      (grant)
  );

  always #5 clk = ~clk;

  // FWFT FIFO heads: each pop exposes the next sequence number
  assign src0_data = {8'hC0, fptr0};
  assign src1_data = {8'hC1, fptr1};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_rd_en[0]) begin fptr0 <= fptr0 + 16'd1; pops0 <= pops0 + 1; end
    if (src_rd_en[1]) begin fptr1 <= fptr1 + 16'd1; pops1 <= pops1 + 1; end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic burst(input logic [1:0] g, input logic [27:0] a, input int cmd_dly,
                       input bit stall, input bit drop, input int fs_beat,
                       input int rst_beat, input logic [1:0] exp_fd);
    int n, beats, p0, p1, idx;
    bit tog, fs_sent;
    logic [15:0] e;
    idx = g[1] ? 1 : 0;
    n = 0;
    while (mem_if.cmd_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("cmd_seen", mem_if.cmd_valid, 1);
    last_cmd_cyc = cyc;
    p0 = pops0;
    p1 = pops1;
    chk("grant", grant, g);
    chk("cmd_addr", mem_if.cmd_addr, a);
    chk("cmd_len", mem_if.cmd_len, BL - 1);
    if (drop) src_req = 2'b00;
    for (int i = 0; i < cmd_dly; i++) begin
      @(negedge clk);
      chk("cmd_hold_valid", mem_if.cmd_valid, 1);
      chk("cmd_hold_addr", mem_if.cmd_addr, a);
      chk("cmd_hold_len", mem_if.cmd_len, BL - 1);
      chk("cmd_hold_wr_valid", mem_if.wr_valid, 0);
    end
    mem_if.cmd_ready = 1'b1;
    @(negedge clk);
    mem_if.cmd_ready = 1'b0;
    beats = 0; n = 0; tog = 1'b0; fs_sent = 1'b0;
    while (beats < BL && n < 400) begin
      if (beats == rst_beat) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {grant, src_rd_en, frame_done, mem_if.cmd_valid, mem_if.wr_valid, mem_if.wr_last}, 0);
        chk("rst_bus", {mem_if.cmd_addr, mem_if.wr_data, mem_if.cmd_len}, 0);
        mem_if.wr_ready = 1'b0;
        return;
      end
      src_fs = (beats == fs_beat && !fs_sent) ? 2'b11 : 2'b00;
      if (src_fs != 2'b00) fs_sent = 1'b1;
      mem_if.wr_ready = stall ? tog : 1'b1;
      tog = ~tog;
      #1;
      e = 16'(exp_ptr[idx]);
      chk("wr_valid", mem_if.wr_valid, 1);
      chk("wr_data", mem_if.wr_data, {(idx == 1) ? 8'hC1 : 8'hC0, e});
      chk("wr_last", mem_if.wr_last, (beats == BL - 1));
      chk("grant_data", grant, g);
      if (mem_if.wr_ready) begin exp_ptr[idx]++; beats++; end
      @(negedge clk);
      n++;
    end
    src_fs = 2'b00;
    mem_if.wr_ready = 1'b0;
    #1;
    chk("beats", beats, BL);
    chk("done_wr_valid", mem_if.wr_valid, 0);
    chk("frame_done", frame_done, exp_fd);
    chk("pops_own", (idx == 1) ? pops1 - p1 : pops0 - p0, BL);
    chk("pops_other", (idx == 1) ? pops0 - p0 : pops1 - p1, 0);
  endtask

  initial begin
    rst_n = 1'b0; src_req = 2'b00; src_fs = 2'b00;
    mem_if.cmd_ready = 1'b0; mem_if.wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {grant, src_rd_en, frame_done, mem_if.cmd_valid, mem_if.wr_valid, mem_if.wr_last}, 0);
    chk("reset_bus", {mem_if.cmd_addr, mem_if.wr_data, mem_if.cmd_len}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // camera 0 alone
    src_req = 2'b01;
    burst(2'b01, 28'h000_0000, 0, 0, 0, -1, -1, 2'b00);
    burst(2'b01, 28'h000_0040, 0, 0, 0, -1, -1, 2'b00);

    // both requesting: priority alternates, starting with camera 1
    src_req = 2'b11;
    burst(2'b10, 28'h010_0000, 0, 0, 0, -1, -1, 2'b00);
    t0 = last_cmd_cyc;
    burst(2'b01, 28'h000_0080, 0, 0, 0, -1, -1, 2'b00);
    chk("burst_period", last_cmd_cyc - t0, BL + 3);
    burst(2'b10, 28'h010_0040, 0, 0, 0, -1, -1, 2'b00);
    burst(2'b01, 28'h000_00C0, 0, 0, 0, -1, -1, 2'b00);

    // stalled command and data, request withdrawn after grant
    src_req = 2'b01;
    burst(2'b01, 28'h000_0100, 5, 1, 1, -1, -1, 2'b00);
    src_req = 2'b01;

    for (int i = 0; i < 11; i++)
      burst(2'b01, 28'(32'h140 + i * 64), 0, 0, 0, -1, -1, 2'b00);
    // frame start on both cameras mid-burst of camera 0 at pix_cnt 0x400
    burst(2'b01, 28'h000_0400, 0, 0, 0, 20, -1, 2'b00);
    burst(2'b01, 28'h000_0000, 0, 0, 0, -1, -1, 2'b00);

    // run camera 0 to the end of its frame
    for (int i = 1; i < (HD * VD) / BL; i++)
      burst(2'b01, 28'(i * 64), 0, 0, 0, -1, -1, (i == (HD * VD) / BL - 1) ? 2'b01 : 2'b00);
    burst(2'b01, 28'h000_0000, 0, 0, 0, -1, -1, 2'b00);

    // camera 1 counter was cleared by its frame start
    src_req = 2'b10;
    burst(2'b10, 28'h010_0000, 0, 0, 0, -1, -1, 2'b00);
    src_req = 2'b01;
    burst(2'b01, 28'h000_0040, 0, 0, 0, -1, -1, 2'b00);

    // reset in the middle of a burst
    burst(2'b01, 28'h000_0080, 0, 0, 0, -1, 30, 2'b00);
    src_req = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_hold_grant", grant, 0);
    rst_n = 1'b1;
    burst(2'b01, 28'h000_0000, 0, 0, 0, -1, -1, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
